// File: rtl/latrnq_ctrl_pkg.sv
// latrnq_ctrl_pkg: shared states, timing defaults and helpers for the latch bank write controller
package latrnq_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CLR, REC} state_t;
  localparam int DEF_DW = 8;
  localparam int DEF_AW = 2;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC = 1;
  localparam int DEF_CLR_CYC = 2;
  localparam int DEF_REC_CYC = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
    return r;
  endfunction
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/latrnq_phase_timer.sv
// latrnq_phase_timer: loadable down-counter that flags when the current phase has run out
module latrnq_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign done = (cnt == '0);
endmodule

// File: rtl/latrnq_bank_wr_ctrl.sv
// latrnq_bank_wr_ctrl: sequences D/E/RN of a latch register bank with cycle-counted setup, hold and clear timing
module latrnq_bank_wr_ctrl
  import latrnq_ctrl_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int AW        = DEF_AW,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int CLR_CYC   = DEF_CLR_CYC,
  parameter int REC_CYC   = DEF_REC_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wreq,
  input  logic [AW-1:0]        waddr,
  input  logic [DW-1:0]        wdata,
  output logic                 wack,
  input  logic                 clrreq,
  output logic                 clrack,
  output logic                 busy,
  output logic [DW-1:0]        ld,
  output logic [(1<<AW)-1:0]   le,
  output logic                 lrn
);
  localparam int ROWS = 1 << AW;
  localparam int CW = clog2(max2(max2(max2(SETUP_CYC, PULSE_CYC), max2(HOLD_CYC, CLR_CYC)), REC_CYC) + 1);
  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 || CLR_CYC < 1 || REC_CYC < 1) begin : g_bad_cyc
    $error("latrnq_bank_wr_ctrl: every *_CYC parameter must be at least 1");
  end
  state_t          state, nxt;
  logic [AW-1:0]   addr;
  logic            from_clr;
  logic            load;
  logic [CW-1:0]   load_val;
  logic            done;
  logic [ROWS-1:0] one_hot;
  latrnq_phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );
  // The ack cycle is a bubble so a level requester can drop its request in time.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (wack || clrack) ? IDLE : clrreq ? CLR : wreq ? SETUP : IDLE;
      SETUP:   nxt = done ? PULSE : SETUP;
      PULSE:   nxt = done ? HOLD : PULSE;
      HOLD:    nxt = done ? IDLE : HOLD;
      CLR:     nxt = done ? REC : CLR;
      REC:     nxt = (done && lrn) ? IDLE : REC;
      default: nxt = IDLE;
    endcase
  end
  // REC with lrn still low is the first cycle out of reset: start the recovery count there.
  assign load = (nxt != IDLE) && ((nxt != state) || (state == REC && !lrn));
  assign load_val = (nxt == SETUP) ? CW'(SETUP_CYC - 1) :
                    (nxt == PULSE) ? CW'(PULSE_CYC - 1) :
                    (nxt == HOLD)  ? CW'(HOLD_CYC - 1)  :
                    (nxt == CLR)   ? CW'(CLR_CYC - 1)   : CW'(REC_CYC - 1);
  assign one_hot = ROWS'(1) << addr;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REC;
      addr     <= '0;
      from_clr <= 1'b0;
      ld       <= '0;
      le       <= '0;
      lrn      <= 1'b0;
      wack     <= 1'b0;
      clrack   <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state    <= nxt;
      busy     <= (nxt != IDLE);
      wack     <= (state == HOLD) && (nxt == IDLE);
      clrack   <= (state == REC) && (nxt == IDLE) && from_clr;
      le       <= (nxt == PULSE) ? one_hot : '0;
      lrn      <= (nxt != CLR);
      from_clr <= (nxt == CLR) ? 1'b1 : (nxt == IDLE) ? 1'b0 : from_clr;
      if (state == IDLE && nxt == SETUP) begin
        ld   <= wdata;
        addr <= waddr;
      end
    end
  end
endmodule
